// File: rtl/s2a_capture_sched.sv
`default_nettype none
// == s2a_capture_sched : arm/sync/trigger sequencer gating 16-sample blocks into S2A against ping-pong credits ==
// == rev 1.0 ==
module s2a_capture_sched #(
  parameter int CNT_W    = 24,
  parameter int SYNC_LEN = 2
) (
  input  logic             rst,
  input  logic             Sclk,
  input  logic             cfg_arm,
  input  logic             cfg_abort,
  input  logic             cfg_cont,
  input  logic [CNT_W-1:0] cfg_nblk,
  input  logic             cfg_trig_en,
  input  logic             trig,
  input  logic             in_valid,
  input  logic             blk_done,
  output logic             sync,
  output logic             Ien,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SYNC      = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_RUN       = 3'd3,
    ST_DRAIN     = 3'd4
  } state_t;

  localparam int                c_SC_W        = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam logic [c_SC_W-1:0] c_SYNC_LAST   = c_SC_W'(SYNC_LEN - 1);
  localparam logic [1:0]        c_CREDIT_FULL = 2'd2;

  state_t            state_q, state_d;
  logic [c_SC_W-1:0] sync_cnt_q, sync_cnt_d;
  logic              sync_q, sync_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              trig_dly_q;
  logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
  logic [CNT_W-1:0]  nblk_q, nblk_d;
  logic [3:0]        scnt_q, scnt_d;
  logic [1:0]        credit_q, credit_d;
  logic              cont_q, cont_d;
  logic              trig_en_q, trig_en_d;

  logic w_trig_edge, w_blk_start, w_ien, w_dec;

  always_ff @(posedge Sclk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      sync_cnt_q <= '0;
      sync_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      trig_dly_q <= 1'b0;
      blk_cnt_q  <= '0;
      nblk_q     <= '0;
      scnt_q     <= 4'd0;
      credit_q   <= c_CREDIT_FULL;
      cont_q     <= 1'b0;
      trig_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      sync_q     <= sync_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      trig_dly_q <= trig;
      blk_cnt_q  <= blk_cnt_d;
      nblk_q     <= nblk_d;
      scnt_q     <= scnt_d;
      credit_q   <= credit_d;
      cont_q     <= cont_d;
      trig_en_q  <= trig_en_d;
    end
  end

  // A new block may only start when a buffer half is free; mid-block samples are always taken.
  assign w_trig_edge = trig & ~trig_dly_q;
  assign w_blk_start = (scnt_q == 4'd0);
  assign w_ien       = (state_q == ST_RUN) & in_valid & ~cfg_abort &
                       (~w_blk_start | (credit_q != 2'd0));
  assign w_dec       = w_ien & w_blk_start;

  always_comb begin
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    sync_d     = sync_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    blk_cnt_d  = blk_cnt_q;
    nblk_d     = nblk_q;
    scnt_d     = scnt_q;
    cont_d     = cont_q;
    trig_en_d  = trig_en_q;

    credit_d = credit_q;
    if (blk_done && !w_dec && (credit_q != c_CREDIT_FULL)) begin
      credit_d = credit_q + 2'd1;
    end else if (w_dec && !blk_done) begin
      credit_d = credit_q - 2'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_arm) begin
          state_d    = ST_SYNC;
          sync_d     = 1'b1;
          sync_cnt_d = '0;
          blk_cnt_d  = '0;
          ovf_d      = 1'b0;
          scnt_d     = 4'd0;
          credit_d   = c_CREDIT_FULL;
          cont_d     = cfg_cont;
          nblk_d     = cfg_nblk;
          trig_en_d  = cfg_trig_en;
        end
      end
      ST_SYNC: begin
        if (sync_cnt_q == c_SYNC_LAST) begin
          sync_d  = 1'b0;
          state_d = trig_en_q ? ST_WAIT_TRIG : ST_RUN;
        end else begin
          sync_cnt_d = sync_cnt_q + c_SC_W'(1);
        end
      end
      ST_WAIT_TRIG: begin
        if (w_trig_edge) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (w_ien) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == 4'd15) begin
            blk_cnt_d = blk_cnt_q + CNT_W'(1);
            if (!cont_q && (nblk_q != '0) && ((blk_cnt_q + CNT_W'(1)) == nblk_q)) begin
              state_d = ST_DRAIN;
            end
          end
        end else if (in_valid && w_blk_start && (credit_q == 2'd0) && !cfg_abort) begin
          ovf_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (credit_q == c_CREDIT_FULL) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && cfg_abort) begin
      state_d = ST_IDLE;
      sync_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign sync    = sync_q;
  assign Ien     = w_ien;
  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign ovf     = ovf_q;
  assign blk_cnt = blk_cnt_q;

endmodule
`default_nettype wire
